regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32x32 integer register file's single write port. It shares that port between two requesters: the in-order pipeline write-back stage (port A), which has priority, and a long-latency unit such as a divider or load unit (port B), which uses a valid/ready handshake. A bounded-wait starvation guard stalls the pipeline so that B always completes. A 32-bit pending-write scoreboard tracks registers owed by B so that issue logic can detect RAW hazards.

## Interface
Parameters:
- MAX_WAIT, default 4: cycles B may wait with b_valid high and no grant before the arbiter forces a grant; legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  pipeline write-back request this cycle.
- a_rd  in  5  port A destination register.
- a_data  in  32  port A write data.
- b_valid  in  1  long-latency unit result valid.
- b_rd  in  5  port B destination register.
- b_data  in  32  port B write data.
- b_ready  out  1  port B accepted this cycle; a handshake is b_valid & b_ready.
- stall_pipe  out  1  freezes the pipeline; port A is not written and must hold its request.
- iss_valid  in  1  an instruction destined for B is dispatched this cycle.
- iss_rd  in  5  destination register of the dispatched instruction.
- addr_rs1, addr_rs2  in  5  each  source registers to look up in the scoreboard.
- busy_rs1, busy_rs2  out  1  each  the looked-up register has a pending B write.
- rf_write_enable  out  1  register file write enable.
- rf_addr_rd  out  5  register file write address.
- rf_data_rd  out  32  register file write data.

## Operation
- Registered state:
  - 1-bit FSM: NORMAL or STARVE.
  - 4-bit wait_cnt.
  - 32-bit busy vector; busy[0] is hardwired to 0.
- Port A effective request: a_eff = a_valid & (a_rd != 0) & !stall_pipe. A request to x0 does not occupy the write port.
- NORMAL state:
  - stall_pipe = 0.
  - b_ready = b_valid & !a_eff.
  - If a_eff: write port = A.
  - Else if b_valid: write port = B.
  - Else: rf_write_enable = 0.
- STARVE state:
  - stall_pipe = 1.
  - b_ready = 1.
  - Write port = B when b_valid; port A is ignored.
- rf_write_enable is 1 only for a granted request whose rd != 0. A B handshake with b_rd = 0 completes, but does not write.
- wait_cnt:
  - Clears on any B handshake, or whenever b_valid = 0.
  - Otherwise increments in NORMAL when b_valid & !b_ready.
- FSM transitions:
  - NORMAL -> STARVE when b_valid & !b_ready & (wait_cnt == MAX_WAIT-1).
  - STARVE -> NORMAL on a B handshake.
  - STARVE also returns to NORMAL if b_valid drops; this is a protocol violation that must be tolerated.
- Port B handshake protocol: once b_valid is asserted, b_rd and b_data hold until the handshake.
- Scoreboard update per edge:
  - Set: if iss_valid & (iss_rd != 0), busy[iss_rd] <= 1.
  - Clear: on a B handshake with b_rd != 0, busy[b_rd] <= 0.
  - If set and clear target the same register in one cycle, set wins (a new in-order B op).
- Lookup: busy_rs1 = busy[addr_rs1] and busy_rs2 = busy[addr_rs2], combinational from the registered vector. The lookup does not bypass same-cycle set/clear.
- B results are assumed to return in dispatch order. The block does not check this.

## Timing
- Outputs rf_*, b_ready and stall_pipe are combinational from the inputs and registered state, giving zero-latency grants. The register file commits the write on the same rising edge.
- Reset (synchronous): FSM = NORMAL, wait_cnt = 0, busy = 0.
- While reset is high: rf_write_enable = 0, b_ready = 0, stall_pipe = 0, busy_rs1 = 0, busy_rs2 = 0.
- Reset asserted mid-STARVE returns to NORMAL on the next edge. A pending B request is not lost: it stays valid and is re-arbitrated.
- Worst-case B latency from b_valid rising to handshake: MAX_WAIT + 1 cycles (MAX_WAIT denied cycles, then one STARVE cycle).
- stall_pipe is high for exactly one cycle per starvation event, provided b_valid holds.
- A scoreboard bit set at edge N is visible on busy_rs* from cycle N+1. A bit cleared at edge N reads 0 from cycle N+1.

## Test plan
- Idle/priority: cycle 0 drives a_valid=1, a_rd=5, a_data=0x11 together with b_valid=1, b_rd=6. Required: rf writes x5=0x11 and b_ready=0. Cycle 1 drives a_valid=0. Required: b_ready=1 and rf writes x6.
- x0 pass-through: a_valid=1, a_rd=0 with b_valid=1, b_rd=7, b_data=0xAB. Required: b_ready=1 in the same cycle, rf_addr_rd=7, rf_data_rd=0xAB.
- Starvation (MAX_WAIT=4): a_valid=1 with a_rd=3 every cycle, and b_valid=1 from cycle 0. Required: b_ready=0 in cycles 0-3. Cycle 4: stall_pipe=1, b_ready=1, rf writes B. Cycle 5: NORMAL, with port A written again with its held value.
- Scoreboard: iss_valid with iss_rd=9 at cycle 0. Required: busy_rs1=1 for addr_rs1=9 from cycle 1. Then a B handshake with b_rd=9 at cycle 3. Required: busy_rs1=0 at cycle 4.
- Simultaneous set/clear: iss_rd=9 dispatched in the same cycle as a B handshake with b_rd=9. Required: busy[9] remains 1. Also, iss_rd=0 must never set a bit.
- Reset mid-STARVE: assert reset during the STARVE cycle. Required: next cycle stall_pipe=0, busy vector = 0, wait_cnt restarts from 0, and the held B request is granted once A is idle.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - write-back port, long-latency return, issue and lookup signals
interface regfile_wb_arbiter_if;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        b_ready;
    logic        stall_pipe;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  addr_rs1;
    logic [4:0]  addr_rs2;
    logic        busy_rs1;
    logic        busy_rs2;
    logic        rf_write_enable;
    logic [4:0]  rf_addr_rd;
    logic [31:0] rf_data_rd;

    modport master (
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        output iss_valid, iss_rd, addr_rs1, addr_rs2,
        input  b_ready, stall_pipe, busy_rs1, busy_rs2,
        input  rf_write_enable, rf_addr_rd, rf_data_rd
    );

    modport slave (
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        input  iss_valid, iss_rd, addr_rs1, addr_rs2,
        output b_ready, stall_pipe, busy_rs1, busy_rs2,
        output rf_write_enable, rf_addr_rd, rf_data_rd
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter with starvation guard and pending-write scoreboard
module regfile_wb_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_STARVE = 1'b1
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_cnt_next;
    logic [31:0] busy;
    logic [31:0] busy_next;

    logic        a_eff;
    logic        grant_b;
    logic        b_hs;
    logic        b_ready;
    logic        stall_pipe;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    // Arbitration and write-port mux; everything is quiet while reset is held.
    always_comb begin
        a_eff      = 1'b0;
        grant_b    = 1'b0;
        b_ready    = 1'b0;
        stall_pipe = 1'b0;
        rf_we      = 1'b0;
        rf_addr    = bus.a_rd;
        rf_data    = bus.a_data;
        if (!reset) begin
            case (state)
                ST_NORMAL: begin
                    a_eff = bus.a_valid & (bus.a_rd != 5'd0);
                    if (a_eff) begin
                        rf_we = 1'b1;
                    end else if (bus.b_valid) begin
                        grant_b = 1'b1;
                        b_ready = 1'b1;
                    end
                end
                ST_STARVE: begin
                    stall_pipe = 1'b1;
                    b_ready    = 1'b1;
                    grant_b    = bus.b_valid;
                end
                default: ;
            endcase
        end
        if (grant_b) begin
            rf_we   = (bus.b_rd != 5'd0);
            rf_addr = bus.b_rd;
            rf_data = bus.b_data;
        end
    end

    assign b_hs = bus.b_valid & b_ready;

    always_comb begin
        wait_cnt_next = wait_cnt;
        state_next    = state;
        if (b_hs || !bus.b_valid) begin
            wait_cnt_next = 4'd0;
        end else if (state == ST_NORMAL) begin
            wait_cnt_next = wait_cnt + 4'd1;
        end
        case (state)
            ST_NORMAL: begin
                if (bus.b_valid && !b_ready && (wait_cnt == WAIT_LAST)) begin
                    state_next = ST_STARVE;
                end
            end
            ST_STARVE: begin
                // Leaving on a dropped b_valid tolerates a misbehaving requester.
                if (b_hs || !bus.b_valid) begin
                    state_next = ST_NORMAL;
                end
            end
            default: state_next = ST_NORMAL;
        endcase
    end

    // Set is applied after clear so a same-cycle re-dispatch keeps the bit.
    always_comb begin
        busy_next = busy;
        if (b_hs && (bus.b_rd != 5'd0)) begin
            busy_next[bus.b_rd] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_rd != 5'd0)) begin
            busy_next[bus.iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_NORMAL;
            wait_cnt <= 4'd0;
            busy     <= 32'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            busy     <= busy_next;
        end
    end

    assign bus.b_ready         = b_ready;
    assign bus.stall_pipe      = stall_pipe;
    assign bus.rf_write_enable = rf_we;
    assign bus.rf_addr_rd      = rf_addr;
    assign bus.rf_data_rd      = rf_data;
    assign bus.busy_rs1        = !reset & busy[bus.addr_rs1];
    assign bus.busy_rs2        = !reset & busy[bus.addr_rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.MAX_WAIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle_inputs();
        bus.a_valid   = 1'b0;
        bus.a_rd      = 5'd0;
        bus.a_data    = 32'd0;
        bus.b_valid   = 1'b0;
        bus.b_rd      = 5'd0;
        bus.b_data    = 32'd0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = 5'd0;
        bus.addr_rs1  = 5'd0;
        bus.addr_rs2  = 5'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'h55;
        bus.b_valid = 1'b1; bus.b_rd = 5'd6;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
        bus.addr_rs1 = 5'd4;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (bus.rf_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we c%0d got %b exp 0", c, bus.rf_write_enable); end
            checks++; if (bus.b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready c%0d got %b exp 0", c, bus.b_ready); end
            checks++; if (bus.stall_pipe !== 1'b0) begin errors++; $display("FAIL reset_stall c%0d got %b exp 0", c, bus.stall_pipe); end
            checks++; if (bus.busy_rs1 !== 1'b0) begin errors++; $display("FAIL reset_busy c%0d got %b exp 0", c, bus.busy_rs1); end
            @(negedge clock);
        end
        idle_inputs();
        reset = 1'b0;
        bus.addr_rs1 = 5'd4;
        #1;
        checks++; if (bus.busy_rs1 !== 1'b0) begin errors++; $display("FAIL reset_busy_after got %b exp 0", bus.busy_rs1); end
        checks++; if (bus.rf_write_enable !== 1'b0) begin errors++; $display("FAIL reset_idle_we got %b exp 0", bus.rf_write_enable); end
        @(negedge clock);
    endtask

    task automatic test_priority();
        idle_inputs();
        bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'h11;
        bus.b_valid = 1'b1; bus.b_rd = 5'd6; bus.b_data = 32'h66;
        #1;
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_addr_rd !== 5'd5 || bus.rf_data_rd !== 32'h11)
            begin errors++; $display("FAIL prio_a_write got we=%b rd=%0d data=%h exp we=1 rd=5 data=11", bus.rf_write_enable, bus.rf_addr_rd, bus.rf_data_rd); end
        checks++; if (bus.b_ready !== 1'b0) begin errors++; $display("FAIL prio_b_denied got %b exp 0", bus.b_ready); end
        @(negedge clock);
        bus.a_valid = 1'b0;
        #1;
        checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL prio_b_ready got %b exp 1", bus.b_ready); end
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_addr_rd !== 5'd6 || bus.rf_data_rd !== 32'h66)
            begin errors++; $display("FAIL prio_b_write got we=%b rd=%0d data=%h exp we=1 rd=6 data=66", bus.rf_write_enable, bus.rf_addr_rd, bus.rf_data_rd); end
        @(negedge clock);
        idle_inputs();
        #1;
        checks++; if (bus.rf_write_enable !== 1'b0) begin errors++; $display("FAIL prio_idle_we got %b exp 0", bus.rf_write_enable); end
        @(negedge clock);
    endtask

    task automatic test_x0();
        idle_inputs();
        bus.a_valid = 1'b1; bus.a_rd = 5'd0; bus.a_data = 32'hDEAD;
        bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_data = 32'hAB;
        #1;
        checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL x0_b_ready got %b exp 1", bus.b_ready); end
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_addr_rd !== 5'd7 || bus.rf_data_rd !== 32'hAB)
            begin errors++; $display("FAIL x0_b_write got we=%b rd=%0d data=%h exp we=1 rd=7 data=ab", bus.rf_write_enable, bus.rf_addr_rd, bus.rf_data_rd); end
        @(negedge clock);
        bus.a_valid = 1'b0;
        bus.b_rd = 5'd0; bus.b_data = 32'h77;
        #1;
        checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL x0_brd0_ready got %b exp 1", bus.b_ready); end
        checks++; if (bus.rf_write_enable !== 1'b0) begin errors++; $display("FAIL x0_brd0_we got %b exp 0", bus.rf_write_enable); end
        @(negedge clock);
        idle_inputs();
        @(negedge clock);
    endtask

    task automatic test_starve();
        logic        exp_hit;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        idle_inputs();
        bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'h33;
        bus.b_rd = 5'd8; bus.b_data = 32'h88;
        for (int c = 0; c < 6; c++) begin
            bus.b_valid = (c < 5);
            exp_hit  = (c == 4);
            exp_rd   = exp_hit ? 5'd8 : 5'd3;
            exp_data = exp_hit ? 32'h88 : 32'h33;
            #1;
            checks++; if (bus.b_ready !== exp_hit) begin errors++; $display("FAIL starve_b_ready c%0d got %b exp %b", c, bus.b_ready, exp_hit); end
            checks++; if (bus.stall_pipe !== exp_hit) begin errors++; $display("FAIL starve_stall c%0d got %b exp %b", c, bus.stall_pipe, exp_hit); end
            checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_addr_rd !== exp_rd || bus.rf_data_rd !== exp_data)
                begin errors++; $display("FAIL starve_write c%0d got we=%b rd=%0d data=%h exp we=1 rd=%0d data=%h", c, bus.rf_write_enable, bus.rf_addr_rd, bus.rf_data_rd, exp_rd, exp_data); end
            @(negedge clock);
        end
        idle_inputs();
        @(negedge clock);
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        bus.addr_rs1 = 5'd9; bus.addr_rs2 = 5'd10;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        #1;
        checks++; if (bus.busy_rs1 !== 1'b0) begin errors++; $display("FAIL sb_no_bypass_set got %b exp 0", bus.busy_rs1); end
        @(negedge clock);
        bus.iss_valid = 1'b0;
        for (int c = 1; c < 3; c++) begin
            #1;
            checks++; if (bus.busy_rs1 !== 1'b1) begin errors++; $display("FAIL sb_busy9 c%0d got %b exp 1", c, bus.busy_rs1); end
            checks++; if (bus.busy_rs2 !== 1'b0) begin errors++; $display("FAIL sb_busy10 c%0d got %b exp 0", c, bus.busy_rs2); end
            @(negedge clock);
        end
        bus.b_valid = 1'b1; bus.b_rd = 5'd9; bus.b_data = 32'h99;
        #1;
        checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL sb_b_ready got %b exp 1", bus.b_ready); end
        checks++; if (bus.busy_rs1 !== 1'b1) begin errors++; $display("FAIL sb_no_bypass_clr got %b exp 1", bus.busy_rs1); end
        @(negedge clock);
        bus.b_valid = 1'b0;
        #1;
        checks++; if (bus.busy_rs1 !== 1'b0) begin errors++; $display("FAIL sb_cleared got %b exp 0", bus.busy_rs1); end
        @(negedge clock);
    endtask

    task automatic test_set_clear();
        idle_inputs();
        bus.addr_rs1 = 5'd9; bus.addr_rs2 = 5'd0;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        @(negedge clock);
        bus.b_valid = 1'b1; bus.b_rd = 5'd9; bus.b_data = 32'h90;
        #1;
        checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL sc_b_ready got %b exp 1", bus.b_ready); end
        @(negedge clock);
        bus.iss_valid = 1'b0; bus.b_valid = 1'b0;
        #1;
        checks++; if (bus.busy_rs1 !== 1'b1) begin errors++; $display("FAIL sc_set_wins got %b exp 1", bus.busy_rs1); end
        @(negedge clock);
        bus.b_valid = 1'b1; bus.b_rd = 5'd9;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
        @(negedge clock);
        bus.b_valid = 1'b0;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd31;
        #1;
        checks++; if (bus.busy_rs1 !== 1'b0) begin errors++; $display("FAIL sc_clear9 got %b exp 0", bus.busy_rs1); end
        checks++; if (bus.busy_rs2 !== 1'b0) begin errors++; $display("FAIL sc_x0_never_busy got %b exp 0", bus.busy_rs2); end
        @(negedge clock);
        bus.iss_valid = 1'b0;
        bus.addr_rs2 = 5'd31;
        #1;
        checks++; if (bus.busy_rs2 !== 1'b1) begin errors++; $display("FAIL sc_busy31 got %b exp 1", bus.busy_rs2); end
        @(negedge clock);
    endtask

    task automatic test_reset_starve();
        idle_inputs();
        bus.addr_rs1 = 5'd14; bus.addr_rs2 = 5'd31;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd14;
        bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'h33;
        bus.b_valid = 1'b1; bus.b_rd = 5'd12; bus.b_data = 32'hC;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (bus.b_ready !== 1'b0) begin errors++; $display("FAIL rs_denied c%0d got %b exp 0", c, bus.b_ready); end
            @(negedge clock);
            bus.iss_valid = 1'b0;
        end
        #1;
        checks++; if (bus.stall_pipe !== 1'b1) begin errors++; $display("FAIL rs_starve got %b exp 1", bus.stall_pipe); end
        checks++; if (bus.busy_rs1 !== 1'b1) begin errors++; $display("FAIL rs_busy14_pre got %b exp 1", bus.busy_rs1); end
        reset = 1'b1;
        #1;
        checks++; if (bus.stall_pipe !== 1'b0 || bus.b_ready !== 1'b0 || bus.rf_write_enable !== 1'b0)
            begin errors++; $display("FAIL rs_in_reset got stall=%b rdy=%b we=%b exp 0 0 0", bus.stall_pipe, bus.b_ready, bus.rf_write_enable); end
        @(negedge clock);
        reset = 1'b0;
        for (int c = 5; c < 8; c++) begin
            #1;
            checks++; if (bus.stall_pipe !== 1'b0 || bus.b_ready !== 1'b0)
                begin errors++; $display("FAIL rs_after c%0d got stall=%b rdy=%b exp 0 0", c, bus.stall_pipe, bus.b_ready); end
            checks++; if (bus.busy_rs1 !== 1'b0 || bus.busy_rs2 !== 1'b0)
                begin errors++; $display("FAIL rs_busy_cleared c%0d got %b %b exp 0 0", c, bus.busy_rs1, bus.busy_rs2); end
            checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_addr_rd !== 5'd3)
                begin errors++; $display("FAIL rs_a_write c%0d got we=%b rd=%0d exp we=1 rd=3", c, bus.rf_write_enable, bus.rf_addr_rd); end
            @(negedge clock);
        end
        bus.a_valid = 1'b0;
        #1;
        checks++; if (bus.b_ready !== 1'b1 || bus.stall_pipe !== 1'b0)
            begin errors++; $display("FAIL rs_grant got rdy=%b stall=%b exp 1 0", bus.b_ready, bus.stall_pipe); end
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_addr_rd !== 5'd12 || bus.rf_data_rd !== 32'hC)
            begin errors++; $display("FAIL rs_b_write got we=%b rd=%0d data=%h exp we=1 rd=12 data=c", bus.rf_write_enable, bus.rf_addr_rd, bus.rf_data_rd); end
        @(negedge clock);
        idle_inputs();
        #1;
        checks++; if (bus.stall_pipe !== 1'b0 || bus.rf_write_enable !== 1'b0)
            begin errors++; $display("FAIL rs_quiet got stall=%b we=%b exp 0 0", bus.stall_pipe, bus.rf_write_enable); end
        @(negedge clock);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle_inputs();
        @(negedge clock);
        test_reset();
        test_priority();
        test_x0();
        test_starve();
        test_scoreboard();
        test_set_clear();
        test_reset_starve();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
